// File: rtl/pio_pkg.sv
// Shared codes for the PIO execution controller: opcodes, JMP conditions,
// SET destinations, WAIT sources and the controller state type.
package pio_pkg;

  localparam logic [2:0] OP_JMP  = 3'b000;
  localparam logic [2:0] OP_WAIT = 3'b001;
  localparam logic [2:0] OP_SET  = 3'b111;

  localparam logic [2:0] JC_ALWAYS = 3'b000;
  localparam logic [2:0] JC_X_ZERO = 3'b001;
  localparam logic [2:0] JC_X_DEC  = 3'b010;
  localparam logic [2:0] JC_Y_ZERO = 3'b011;
  localparam logic [2:0] JC_Y_DEC  = 3'b100;
  localparam logic [2:0] JC_X_NE_Y = 3'b101;
  localparam logic [2:0] JC_PIN    = 3'b110;
  localparam logic [2:0] JC_OSR_NE = 3'b111;

  localparam logic [2:0] SD_X = 3'b001;
  localparam logic [2:0] SD_Y = 3'b010;

  localparam logic [1:0] WS_PIN_A  = 2'b00;
  localparam logic [1:0] WS_PIN_B  = 2'b01;
  localparam logic [1:0] WS_IRQ    = 2'b10;
  localparam logic [1:0] WS_ALWAYS = 2'b11;

  typedef enum logic {
    ST_EXEC  = 1'b0,
    ST_DELAY = 1'b1
  } state_e;

  function automatic logic [2:0] instr_opcode(input logic [15:0] instr);
    return instr[15:13];
  endfunction

endpackage

// File: rtl/pio_exec_ctrl_if.sv
// Instruction/status inputs and PC/scratch outputs of the PIO execution controller.
interface pio_exec_ctrl_if #(
  parameter int PIN_W = 8
);
  logic             sm_en;
  logic [15:0]      instr;
  logic [PIN_W-1:0] pins;
  logic [7:0]       irq_flags;
  logic             osr_empty;
  logic             pc_en;
  logic             jump_en;
  logic [3:0]       jump;
  logic [31:0]      x_out;
  logic [31:0]      y_out;

  modport master (
    output sm_en, instr, pins, irq_flags, osr_empty,
    input  pc_en, jump_en, jump, x_out, y_out
  );

  modport slave (
    input  sm_en, instr, pins, irq_flags, osr_empty,
    output pc_en, jump_en, jump, x_out, y_out
  );
endinterface

// File: rtl/pio_jmp_cond.sv
// JMP condition evaluator; purely combinational, uses pre-decrement X/Y values.
module pio_jmp_cond
  import pio_pkg::*;
(
  input  logic [2:0]  cond,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        pin0,
  input  logic        osr_empty,
  output logic        taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      JC_ALWAYS: taken = 1'b1;
      JC_X_ZERO: taken = (x == 32'd0);
      JC_X_DEC:  taken = (x != 32'd0);
      JC_Y_ZERO: taken = (y == 32'd0);
      JC_Y_DEC:  taken = (y != 32'd0);
      JC_X_NE_Y: taken = (x != y);
      JC_PIN:    taken = pin0;
      JC_OSR_NE: taken = ~osr_empty;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pio_exec_ctrl.sv
// PIO execution controller: decodes JMP/WAIT/SET, runs the per-instruction delay,
// drives PC advance/jump and owns scratch registers X and Y.
module pio_exec_ctrl
  import pio_pkg::*;
#(
  parameter int PIN_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  pio_exec_ctrl_if.slave  bus
);

  state_e           r_state, w_state_nxt;
  logic [4:0]       r_cnt, w_cnt_nxt;
  logic [31:0]      r_x, r_y, w_x_nxt, w_y_nxt;

  logic [PIN_W-1:0] w_pins;
  logic [2:0]       w_op;
  logic [4:0]       w_delay;
  logic [2:0]       w_arg;
  logic             w_wait_lvl;
  logic             w_wait_ok;
  logic             w_stall;
  logic             w_taken;
  logic             w_pc_en;
  logic             w_jump_en;

  assign w_pins  = bus.pins;
  assign w_op    = instr_opcode(bus.instr);
  assign w_delay = bus.instr[12:8];
  assign w_arg   = bus.instr[7:5];

  always_comb begin
    w_wait_lvl = 1'b0;
    case (bus.instr[6:5])
      WS_PIN_A, WS_PIN_B: w_wait_lvl = w_pins[bus.instr[2:0]];
      WS_IRQ:             w_wait_lvl = bus.irq_flags[bus.instr[2:0]];
      default:            w_wait_lvl = bus.instr[7];
    endcase
  end

  assign w_wait_ok = (bus.instr[6:5] == WS_ALWAYS) || (w_wait_lvl == bus.instr[7]);
  assign w_stall   = (w_op == OP_WAIT) && !w_wait_ok;

  pio_jmp_cond u_jmp_cond (
    .cond      (w_arg),
    .x         (r_x),
    .y         (r_y),
    .pin0      (w_pins[0]),
    .osr_empty (bus.osr_empty),
    .taken     (w_taken)
  );

  // rst gates the outputs combinationally so nothing advances while it is held.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_pc_en     = 1'b0;
    w_jump_en   = 1'b0;
    if (!rst && bus.sm_en) begin
      if (r_state == ST_EXEC) begin
        if (!w_stall) begin
          w_pc_en = 1'b1;
          if (w_delay != 5'd0) begin
            w_state_nxt = ST_DELAY;
            w_cnt_nxt   = w_delay;
          end
          case (w_op)
            OP_JMP: begin
              w_jump_en = w_taken;
              if (w_arg == JC_X_DEC) w_x_nxt = r_x - 32'd1;
              if (w_arg == JC_Y_DEC) w_y_nxt = r_y - 32'd1;
            end
            OP_SET: begin
              if (w_arg == SD_X) w_x_nxt = {27'd0, bus.instr[4:0]};
              if (w_arg == SD_Y) w_y_nxt = {27'd0, bus.instr[4:0]};
            end
            default: ;
          endcase
        end
      end else begin
        if (r_cnt == 5'd1) begin
          w_state_nxt = ST_EXEC;
          w_cnt_nxt   = 5'd0;
        end else begin
          w_cnt_nxt = r_cnt - 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EXEC;
      r_cnt   <= 5'd0;
      r_x     <= 32'd0;
      r_y     <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  assign bus.pc_en   = w_pc_en;
  assign bus.jump_en = w_jump_en;
  assign bus.jump    = (w_op == OP_JMP) ? bus.instr[3:0] : 4'd0;
  assign bus.x_out   = r_x;
  assign bus.y_out   = r_y;

endmodule

// File: tb/tb_pio_exec_ctrl.sv
// Bench for pio_exec_ctrl: directed scenarios pin the model, then random
// instructions/enables/resets are checked every cycle against an instruction-level model.
module tb_pio_exec_ctrl;

  logic clk = 1'b0;
  logic rst;

  pio_exec_ctrl_if #(.PIN_W(8)) bus ();

  pio_exec_ctrl #(.PIN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: X, Y and the number of delay cycles still owed by the current instruction.
  logic [31:0] m_x, m_y, nx, ny;
  int          m_left, n_left;
  bit          exp_pc, exp_je;
  logic [3:0]  exp_jump;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wait_ok(input logic [15:0] ins, input logic [7:0] p, input logic [7:0] irq);
    int sel;
    bit want;
    sel  = int'(ins[2:0]);
    want = ins[7];
    case (ins[6:5])
      2'd3:    return 1'b1;
      2'd2:    return irq[sel] == want;
      default: return p[sel] == want;
    endcase
  endfunction

  function automatic bit jmp_taken(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                                   input bit p0, input bit osr);
    case (c)
      3'd0: return 1'b1;
      3'd1: return x == 0;
      3'd2: return x != 0;
      3'd3: return y == 0;
      3'd4: return y != 0;
      3'd5: return x != y;
      3'd6: return p0;
      default: return !osr;
    endcase
  endfunction

  task automatic model_eval();
    logic [15:0] ins;
    ins      = bus.instr;
    exp_pc   = 1'b0;
    exp_je   = 1'b0;
    exp_jump = (ins[15:13] == 3'd0) ? ins[3:0] : 4'd0;
    if (rst) begin
      m_x = 0; m_y = 0; m_left = 0;
      nx  = 0; ny  = 0; n_left = 0;
      return;
    end
    nx = m_x; ny = m_y; n_left = m_left;
    if (!bus.sm_en) return;
    if (m_left > 0) begin
      n_left = m_left - 1;
      return;
    end
    if (ins[15:13] == 3'd1 && !wait_ok(ins, bus.pins, bus.irq_flags)) return;
    exp_pc = 1'b1;
    n_left = int'(ins[12:8]);
    case (ins[15:13])
      3'd0: begin
        exp_je = jmp_taken(ins[7:5], m_x, m_y, bus.pins[0], bus.osr_empty);
        if (ins[7:5] == 3'd2) nx = m_x - 1;
        if (ins[7:5] == 3'd4) ny = m_y - 1;
      end
      3'd7: begin
        if (ins[7:5] == 3'd1) nx = {27'd0, ins[4:0]};
        if (ins[7:5] == 3'd2) ny = {27'd0, ins[4:0]};
      end
      default: ;
    endcase
  endtask

  task automatic model_commit();
    if (!rst) begin
      m_x = nx; m_y = ny; m_left = n_left;
    end
  endtask

  task automatic go_neg();
    model_eval();
    @(negedge clk);
    #1;
  endtask

  task automatic go_pos();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic step();
    go_neg();
    go_pos();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_en",   32'(bus.pc_en),   32'(exp_pc));
      check("jump_en", 32'(bus.jump_en), 32'(exp_je));
      check("jump",    32'(bus.jump),    32'(exp_jump));
      check("x_out",   bus.x_out, m_x);
      check("y_out",   bus.y_out, m_y);
    end
  end

  initial begin
    bit seq_sm [7];
    bit seq_pc [7];
    logic [15:0] ins;

    rst = 1'b1;
    bus.sm_en = 1'b1;
    bus.instr = 16'hE025;
    bus.pins = 8'h00;
    bus.irq_flags = 8'h00;
    bus.osr_empty = 1'b1;
    chk_en = 1'b1;

    // Reset state, outputs held low while rst is asserted.
    go_neg();
    check("rst_pc_en", 32'(bus.pc_en), 32'd0);
    check("rst_x", bus.x_out, 32'd0);
    go_pos();

    // SET X,5 executes in the first cycle after release.
    rst = 1'b0;
    go_neg();
    check("set_pc_en", 32'(bus.pc_en), 32'd1);
    check("set_jump_en", 32'(bus.jump_en), 32'd0);
    go_pos();
    check("set_x", bus.x_out, 32'd5);

    // JMP X-- with X=1 jumps, then with X=0 does not and wraps.
    bus.instr = 16'hE021;
    step();
    bus.instr = 16'h0042;
    go_neg();
    check("jmp1_pc_en", 32'(bus.pc_en), 32'd1);
    check("jmp1_jump_en", 32'(bus.jump_en), 32'd1);
    check("jmp1_jump", 32'(bus.jump), 32'd2);
    go_pos();
    check("jmp1_x", bus.x_out, 32'd0);
    go_neg();
    check("jmp0_pc_en", 32'(bus.pc_en), 32'd1);
    check("jmp0_jump_en", 32'(bus.jump_en), 32'd0);
    go_pos();
    check("jmp0_x", bus.x_out, 32'hFFFF_FFFF);

    // WAIT 1 pin 3: stalls four cycles, issues the cycle the pin rises.
    bus.instr = 16'h2083;
    bus.pins = 8'h00;
    for (int i = 0; i < 4; i++) begin
      go_neg();
      check("wait_stall_pc_en", 32'(bus.pc_en), 32'd0);
      go_pos();
    end
    bus.pins = 8'h08;
    go_neg();
    check("wait_go_pc_en", 32'(bus.pc_en), 32'd1);
    go_pos();

    // NOP with delay 3 occupies four cycles.
    bus.instr = 16'hA342;
    for (int i = 0; i < 4; i++) begin
      go_neg();
      check("nop_d3_pc_en", 32'(bus.pc_en), (i == 0) ? 32'd1 : 32'd0);
      go_pos();
    end
    bus.instr = 16'hE025;
    go_neg();
    check("nop_d3_next_pc_en", 32'(bus.pc_en), 32'd1);
    go_pos();

    // Same NOP with sm_en dropped for two cycles mid-delay: period becomes 6.
    seq_sm = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    seq_pc = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.instr = 16'hA342;
    for (int i = 0; i < 7; i++) begin
      bus.sm_en = seq_sm[i];
      go_neg();
      check("freeze_pc_en", 32'(bus.pc_en), 32'(seq_pc[i]));
      go_pos();
    end
    bus.sm_en = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Reset in the middle of a delay with X=7.
    bus.instr = 16'hE027;
    step();
    bus.instr = 16'hA342;
    step();
    step();
    rst = 1'b1;
    go_neg();
    check("mid_rst_pc_en", 32'(bus.pc_en), 32'd0);
    check("mid_rst_x", bus.x_out, 32'd0);
    go_pos();
    rst = 1'b0;
    bus.instr = 16'hE043;
    go_neg();
    check("post_rst_pc_en", 32'(bus.pc_en), 32'd1);
    go_pos();
    check("post_rst_y", bus.y_out, 32'd3);
    check("post_rst_x", bus.x_out, 32'd0);

    // Random traffic checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      ins = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ins[15:13] = 3'b000;
        1: ins[15:13] = 3'b001;
        2: begin
          ins[15:13] = 3'b111;
          ins[4:0]   = 5'($urandom_range(0, 3));
        end
        default: ins[15:13] = 3'($urandom_range(2, 6));
      endcase
      ins[12:8] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 0) ins[12:8] = 5'd0;
      bus.instr     = ins;
      bus.pins      = 8'($urandom);
      bus.irq_flags = 8'($urandom);
      bus.osr_empty = 1'($urandom);
      bus.sm_en     = ($urandom_range(0, 9) != 0);
      rst           = ($urandom_range(0, 127) == 0);
      step();
    end
    rst = 1'b0;
    step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_exec_ctrl.md
PIO_EXEC_CTRL -- requirements
Module: pio_exec_ctrl

Interface
REQ-001 SHALL have parameter: PIN_W, 8, width of GPIO input vector (min 8).
REQ-002 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: sm_en  in  1  state-machine enable; low freezes all state.
REQ-005 SHALL have port: instr  in  16  instruction word at current PC; valid the same cycle, combinational memory read.
REQ-006 SHALL have port: pins  in  PIN_W  GPIO input levels, pre-synchronised.
REQ-007 SHALL have port: irq_flags  in  8  IRQ flag levels.
REQ-008 SHALL have port: osr_empty  in  1  output shift register empty status.
REQ-009 SHALL have port: pc_en  out  1  advance/jump PC at the next edge.
REQ-010 SHALL have port: jump_en  out  1  load PC with jump; meaningful only with pc_en.
REQ-011 SHALL have port: jump  out  4  jump target address.
REQ-012 SHALL have port: x_out, y_out  out  32 each  scratch registers X and Y.

Function
REQ-013 SHALL decode instr[15:13] as opcode: 000 JMP, 001 WAIT, 111 SET; all others SHALL be NOPs that execute in one cycle.
REQ-014 SHALL treat instr[12:8] as the delay count D (0-31) for every opcode.
REQ-015 SHALL implement a two-state FSM, EXEC and DELAY, plus a 5-bit delay counter.
REQ-016 In EXEC with sm_en=1 and the instruction not stalled, SHALL assert pc_en=1 combinationally for that cycle and apply side effects at the edge.
  - If D=0: remain in EXEC.
  - Else: go to DELAY with counter=D.
REQ-017 In DELAY, SHALL hold pc_en=0 and decrement the counter each sm_en cycle; counter==1 -> EXEC at the next edge, so an instruction occupies 1+D cycles.
REQ-018 JMP SHALL drive jump=instr[3:0] (instr[4] ignored) and jump_en=1 iff the condition in instr[7:5] is true. Conditions:
  - 000 always.
  - 001 X==0.
  - 010 X!=0 (pre-decrement).
  - 011 Y==0.
  - 100 Y!=0 (pre-decrement).
  - 101 X!=Y.
  - 110 pins[0]==1.
  - 111 osr_empty==0.
REQ-019 JMP condition 010 SHALL decrement X by 1 modulo 2^32 whether or not the jump is taken; condition 100 SHALL do the same for Y. X=0 therefore gives no jump and X=0xFFFFFFFF.
REQ-020 WAIT SHALL stall (pc_en=0, no state change, delay not started) until the selected level equals polarity instr[7]. Source is selected by instr[6:5]:
  - 00 or 01: pins[instr[2:0]].
  - 10: irq_flags[instr[2:0]].
  - 11: always satisfied.
REQ-021 The stall SHALL re-evaluate every cycle; pc_en SHALL assert in the same cycle the condition becomes true.
REQ-022 SET SHALL load the zero-extended instr[4:0] into X when dest instr[7:5]=001, into Y when it is 010; other dest values SHALL be a NOP.
REQ-023 jump_en SHALL be 0 whenever pc_en=0, and jump SHALL be 0 when the opcode is not JMP.
REQ-024 sm_en=0 SHALL force pc_en=0 and jump_en=0 and freeze state, counter, X and Y. On re-enable, execution SHALL resume exactly where it stopped.
REQ-025 Only this block SHALL modify X and Y.

Reset
REQ-026 rst=1 SHALL asynchronously set state=EXEC, counter=0, X=0, Y=0, and SHALL force pc_en=0 and jump_en=0 while asserted, including when asserted mid-DELAY or mid-WAIT.
REQ-027 The first cycle after reset release SHALL execute the instruction at the PC's reset address.

Structure
REQ-028 Opcode codes, JMP condition codes, SET destination codes, WAIT source codes and the EXEC/DELAY state type SHALL reside in shared package pio_pkg.
REQ-029 JMP condition evaluation SHALL be one combinational sub-module, pio_jmp_cond (inputs: cond, X, Y, pins[0], osr_empty; output: taken).

Verification
REQ-030 Reset, instr=0xE025 (SET X,5) -> pc_en=1, jump_en=0 that cycle; x_out=5 after the edge.
REQ-031 X=1, instr=0x0042 (JMP X-- 2) -> pc_en=1, jump_en=1, jump=2, then X=0. Repeat with X=0 -> jump_en=0, then X=0xFFFFFFFF.
REQ-032 instr=0x2083 (WAIT 1 pin 3), pins[3]=0 for 4 cycles then 1 -> pc_en=0 for 4 cycles, then pc_en=1 in the cycle pins[3] rises.
REQ-033 instr=0xA342 (NOP, D=3) -> pc_en sequence 1,0,0,0, then 1 for the next instruction.
REQ-034 instr=0xA342 with sm_en=0 for 2 cycles mid-DELAY -> DELAY extended by exactly 2 cycles; total pc_en period 6 cycles.
REQ-035 rst pulsed during DELAY with X=7 -> pc_en=0 during rst; afterwards state=EXEC, x_out=0, next instruction executes immediately.
